motor_trip_controller: RTL and testbench

Protection state machine directly downstream of the motor fault detector. Consumes the debounced `fault_detected` flag, cuts the motor enable, waits out a cooldown and then auto-restarts. After a configurable number of consecutive failed restarts it latches a lockout that only an explicit clear releases. Drives the PWM stage enable and reports status to the supervisor.

---
 rtl/motor_ctrl_pkg.sv | 25 ++
 rtl/cycle_timer.sv | 37 +++
 rtl/motor_trip_controller.sv | 154 +++++++++++++++
 tb/tb_motor_trip_controller.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/motor_ctrl_pkg.sv
// Shared definitions for the motor trip controller and the supervisor that
// decodes its state output.
package motor_ctrl_pkg;

    localparam int STATE_W      = 3;
    localparam int RETRY_W      = 4;
    localparam int TRIP_TOTAL_W = 8;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE     = 3'd0,
        ST_RUN      = 3'd1,
        ST_TRIP     = 3'd2,
        ST_COOLDOWN = 3'd3,
        ST_LOCKOUT  = 3'd4
    } state_e;

    function automatic logic [RETRY_W-1:0] sat_inc_retry(input logic [RETRY_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    function automatic logic [TRIP_TOTAL_W-1:0] sat_inc_total(input logic [TRIP_TOTAL_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter that stops at zero and flags it; load wins over
// decrement.
module cycle_timer #(
    parameter int MAX_COUNT = 1000
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           load,
    input  logic [$clog2(MAX_COUNT+1)-1:0] load_val,
    input  logic                           dec,
    output logic                           zero
);

    localparam int W = $clog2(MAX_COUNT + 1);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/motor_trip_controller.sv
// Motor protection FSM: trips on fault, cools down, auto-restarts, and
// latches a lockout after too many consecutive failed restarts.
module motor_trip_controller
    import motor_ctrl_pkg::*;
#(
    parameter int COOLDOWN_CYCLES = 1000,
    parameter int MAX_RETRIES     = 3,
    parameter int HEALTHY_CYCLES  = 5000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    fault_detected,
    input  logic                    start_cmd,
    input  logic                    stop_cmd,
    input  logic                    clear_lockout,
    output logic                    motor_en,
    output logic                    lockout,
    output logic                    trip_pulse,
    output logic [STATE_W-1:0]      state,
    output logic [RETRY_W-1:0]      retry_cnt,
    output logic [TRIP_TOTAL_W-1:0] trip_total
);

    localparam int COOL_W = $clog2(COOLDOWN_CYCLES + 1);
    localparam int HLTH_W = $clog2(HEALTHY_CYCLES + 1);
    localparam logic [COOL_W-1:0] COOL_LOAD = COOL_W'(COOLDOWN_CYCLES);
    localparam logic [HLTH_W-1:0] HLTH_LOAD = HLTH_W'(HEALTHY_CYCLES - 1);

    state_e                  state_q, state_d;
    logic [RETRY_W-1:0]      retry_q, retry_d, retry_base;
    logic [TRIP_TOTAL_W-1:0] total_q, total_d;

    logic              cool_load, cool_dec, cool_zero;
    logic [COOL_W-1:0] cool_val;
    logic              hlth_load, hlth_dec, hlth_zero;
    logic [HLTH_W-1:0] hlth_val;

    cycle_timer #(.MAX_COUNT(COOLDOWN_CYCLES)) u_cool_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cool_load),
        .load_val (cool_val),
        .dec      (cool_dec),
        .zero     (cool_zero)
    );

    // Healthy timer holds HEALTHY_CYCLES-1 on RUN entry so it hits zero on
    // the HEALTHY_CYCLES-th RUN cycle.
    cycle_timer #(.MAX_COUNT(HEALTHY_CYCLES)) u_hlth_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (hlth_load),
        .load_val (hlth_val),
        .dec      (hlth_dec),
        .zero     (hlth_zero)
    );

    always_comb begin
        state_d    = state_q;
        retry_d    = retry_q;
        retry_base = retry_q;
        total_d    = total_q;
        cool_load  = 1'b0;
        cool_val   = COOL_LOAD;
        cool_dec   = 1'b0;
        hlth_load  = 1'b0;
        hlth_val   = HLTH_LOAD;
        hlth_dec   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_cmd && !fault_detected) begin
                    state_d   = ST_RUN;
                    hlth_load = 1'b1;
                end
            end
            ST_RUN: begin
                // A run that completes its healthy window this cycle counts as healthy
                // even if a fault arrives on the same edge.
                if (hlth_zero) begin
                    retry_base = '0;
                    hlth_load  = 1'b1;
                end else begin
                    hlth_dec = 1'b1;
                end
                retry_d = retry_base;
                if (fault_detected) begin
                    state_d   = ST_TRIP;
                    retry_d   = sat_inc_retry(retry_base);
                    total_d   = sat_inc_total(total_q);
                    hlth_load = 1'b1;
                    hlth_val  = '0;
                end else if (stop_cmd) begin
                    state_d   = ST_IDLE;
                    hlth_load = 1'b1;
                    hlth_val  = '0;
                end
            end
            ST_TRIP: begin
                if (int'(retry_q) > MAX_RETRIES) begin
                    state_d = ST_LOCKOUT;
                end else begin
                    state_d   = ST_COOLDOWN;
                    cool_load = 1'b1;
                end
            end
            ST_COOLDOWN: begin
                if (stop_cmd) begin
                    state_d   = ST_IDLE;
                    cool_load = 1'b1;
                    cool_val  = '0;
                end else if (cool_zero) begin
                    if (fault_detected) begin
                        cool_load = 1'b1;
                    end else begin
                        state_d   = ST_RUN;
                        hlth_load = 1'b1;
                    end
                end else begin
                    cool_dec = 1'b1;
                end
            end
            ST_LOCKOUT: begin
                if (clear_lockout) begin
                    state_d = ST_IDLE;
                    retry_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            retry_q <= '0;
            total_q <= '0;
        end else begin
            state_q <= state_d;
            retry_q <= retry_d;
            total_q <= total_d;
        end
    end

    assign state      = state_q;
    assign motor_en   = (state_q == ST_RUN);
    assign lockout    = (state_q == ST_LOCKOUT);
    assign trip_pulse = (state_q == ST_TRIP);
    assign retry_cnt  = retry_q;
    assign trip_total = total_q;

endmodule

// File: tb/tb_motor_trip_controller.sv
// Self-checking bench for motor_trip_controller: fixed vector table, directed
// corner sequences, then random stimulus against a behavioural model.
module tb_motor_trip_controller;

    localparam int COOL = 10;
    localparam int MAXR = 2;
    localparam int HLTH = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       fault_detected = 1'b0;
    logic       start_cmd = 1'b0;
    logic       stop_cmd = 1'b0;
    logic       clear_lockout = 1'b0;
    logic       motor_en, lockout, trip_pulse;
    logic [2:0] state;
    logic [3:0] retry_cnt;
    logic [7:0] trip_total;

    int checks = 0;
    int failures = 0;

    // Behavioural model: mode uses the externally visible state codes, run_len
    // counts RUN cycles since entry, cool_elapsed counts finished cooldown cycles.
    int m_mode, m_retry, m_total, m_run_len, m_cool_elapsed;

    typedef struct {
        bit         s, p, f, c;
        logic [2:0] st;
        bit         en;
        logic [3:0] retry;
        logic [7:0] total;
    } vec_t;

    vec_t tbl[12];

    motor_trip_controller #(
        .COOLDOWN_CYCLES (COOL),
        .MAX_RETRIES     (MAXR),
        .HEALTHY_CYCLES  (HLTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fault_detected (fault_detected),
        .start_cmd      (start_cmd),
        .stop_cmd       (stop_cmd),
        .clear_lockout  (clear_lockout),
        .motor_en       (motor_en),
        .lockout        (lockout),
        .trip_pulse     (trip_pulse),
        .state          (state),
        .retry_cnt      (retry_cnt),
        .trip_total     (trip_total)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(bit s, bit p, bit f, bit c, int st, bit en, int r, int t);
        vec_t v;
        v.s = s; v.p = p; v.f = f; v.c = c;
        v.st = 3'(st); v.en = en; v.retry = 4'(r); v.total = 8'(t);
        return v;
    endfunction

    function automatic logic [17:0] expVec(int st, bit en, bit lk, bit pl, int r, int t);
        return {3'(st), en, lk, pl, 4'(r), 8'(t)};
    endfunction

    function automatic logic [17:0] modelVec();
        return expVec(m_mode, m_mode == 1, m_mode == 4, m_mode == 2, m_retry, m_total);
    endfunction

    task automatic modelReset();
        m_mode = 0; m_retry = 0; m_total = 0; m_run_len = 0; m_cool_elapsed = 0;
    endtask

    task automatic modelStep(input bit s, input bit p, input bit f, input bit c);
        case (m_mode)
            0: if (s && !f) begin m_mode = 1; m_run_len = 0; end
            1: begin
                m_run_len++;
                if (m_run_len % HLTH == 0) m_retry = 0;
                if (f) begin
                    m_mode  = 2;
                    m_retry = (m_retry < 15) ? m_retry + 1 : 15;
                    m_total = (m_total < 255) ? m_total + 1 : 255;
                end else if (p) begin
                    m_mode = 0;
                end
            end
            2: begin
                m_mode = (m_retry > MAXR) ? 4 : 3;
                m_cool_elapsed = 0;
            end
            3: begin
                if (p) m_mode = 0;
                else if (m_cool_elapsed == COOL) begin
                    if (f) m_cool_elapsed = 0;
                    else begin m_mode = 1; m_run_len = 0; end
                end else m_cool_elapsed++;
            end
            4: if (c) begin m_mode = 0; m_retry = 0; end
            default: m_mode = 0;
        endcase
    endtask

    task automatic applyStimulus(input bit s, input bit p, input bit f, input bit c);
        start_cmd = s; stop_cmd = p; fault_detected = f; clear_lockout = c;
        modelStep(s, p, f, c);
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [17:0] exp);
        logic [17:0] got;
        got = {state, motor_en, lockout, trip_pulse, retry_cnt, trip_total};
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got state=%0d en=%0b lock=%0b pulse=%0b retry=%0d total=%0d, expected state=%0d en=%0b lock=%0b pulse=%0b retry=%0d total=%0d",
                     name, got[17:15], got[14], got[13], got[12], got[11:8], got[7:0],
                     exp[17:15], exp[14], exp[13], exp[12], exp[11:8], exp[7:0]);
        end
    endtask

    task automatic checkValue(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic step(input bit s, input bit p, input bit f, input bit c, input string name);
        applyStimulus(s, p, f, c);
        checkOutput(name, modelVec());
    endtask

    // Called just after an edge; drops reset between edges and checks at once.
    task automatic asyncReset(input string name);
        start_cmd = 0; stop_cmd = 0; fault_detected = 0; clear_lockout = 0;
        #2 rst_n = 1'b0;
        #1 checkOutput(name, '0);
        modelReset();
        #2 rst_n = 1'b1;
    endtask

    // Step idle until the motor restarts, counting cooldown cycles; bounded.
    task automatic waitRestart(input string name, output int cool_cnt);
        cool_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            step(0, 0, 0, 0, name);
            if (state == 3'd3) cool_cnt++;
            if (motor_en) break;
        end
        checkValue({name, "_restarted"}, int'(motor_en), 1);
    endtask

    initial begin
        int cool_cnt;
        int pulses;
        bit s, p, f, c;

        tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 0, 0, 0, 1, 1, 0, 0);
        tbl[2]  = mk(0, 0, 0, 0, 1, 1, 0, 0);
        tbl[3]  = mk(0, 0, 1, 0, 2, 0, 1, 1);
        tbl[4]  = mk(0, 0, 0, 0, 3, 0, 1, 1);
        tbl[5]  = mk(1, 0, 0, 0, 3, 0, 1, 1);
        tbl[6]  = mk(0, 1, 0, 0, 0, 0, 1, 1);
        tbl[7]  = mk(1, 0, 1, 0, 0, 0, 1, 1);
        tbl[8]  = mk(0, 0, 0, 1, 0, 0, 1, 1);
        tbl[9]  = mk(1, 0, 0, 0, 1, 1, 1, 1);
        tbl[10] = mk(0, 1, 1, 0, 2, 0, 2, 2);
        tbl[11] = mk(0, 0, 0, 0, 3, 0, 2, 2);

        modelReset();
        #12 checkOutput("reset_values", '0);
        #11 rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            applyStimulus(tbl[i].s, tbl[i].p, tbl[i].f, tbl[i].c);
            checkOutput($sformatf("table_%0d", i),
                        expVec(tbl[i].st, tbl[i].en, tbl[i].st == 3'd4, tbl[i].st == 3'd2,
                               tbl[i].retry, tbl[i].total));
        end

        asyncReset("async_reset_cooldown");

        step(1, 0, 0, 0, "start");
        checkOutput("start_run", expVec(1, 1, 0, 0, 0, 0));
        step(0, 0, 1, 0, "trip1");
        checkOutput("trip1_pulse", expVec(2, 0, 0, 1, 1, 1));
        waitRestart("restart1", cool_cnt);
        checkValue("cooldown_len", cool_cnt, COOL + 1);

        for (int t = 0; t < 2; t++) begin
            for (int i = 0; i < 3; i++) step(0, 0, 0, 0, "run_short");
            step(0, 0, 1, 0, "trip_n");
            if (t == 0) waitRestart("restart2", cool_cnt);
        end
        step(0, 0, 0, 0, "enter_lockout");
        checkOutput("lockout_entry", expVec(4, 0, 1, 0, 3, 3));
        step(1, 0, 0, 0, "lockout_start");
        step(0, 1, 0, 0, "lockout_stop");
        checkOutput("lockout_ignores_cmds", expVec(4, 0, 1, 0, 3, 3));
        step(0, 0, 0, 1, "clear");
        checkOutput("lockout_cleared", expVec(0, 0, 0, 0, 0, 3));

        step(1, 0, 0, 0, "persist_start");
        pulses = 0;
        for (int i = 0; i < 25; i++) begin
            step(0, 0, 1, 0, "persist_fault");
            if (trip_pulse) pulses++;
        end
        checkValue("persist_single_pulse", pulses, 1);
        waitRestart("persist", cool_cnt);
        checkValue("persist_retry", int'(retry_cnt), 1);

        for (int i = 0; i < HLTH - 1; i++) step(0, 0, 0, 0, "healthy_run");
        checkValue("healthy_not_yet", int'(retry_cnt), 1);
        step(0, 0, 0, 0, "healthy_run");
        checkValue("healthy_clear", int'(retry_cnt), 0);
        step(0, 1, 1, 0, "fault_vs_stop");
        checkOutput("fault_over_stop", expVec(2, 0, 0, 1, 1, 5));
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, "cooldown_mid");
        asyncReset("async_reset_mid_cooldown");

        step(1, 0, 0, 0, "lk_start");
        for (int t = 0; t < 3; t++) begin
            step(0, 0, 1, 0, "lk_trip");
            if (t < 2) waitRestart("lk_restart", cool_cnt);
        end
        step(0, 0, 0, 0, "lk_enter");
        checkValue("lk_state", int'(state), 4);
        asyncReset("async_reset_lockout");

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(399) == 0) asyncReset("rnd_reset");
            s = ($urandom_range(99) < 15);
            p = ($urandom_range(99) < 3);
            f = ($urandom_range(99) < 6);
            c = ($urandom_range(99) < 10);
            step(s, p, f, c, "random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
